mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency backing memory between the CPU's instruction-fetch port (I, read-only)
//  and data port (D, lw/lbu/sw/sb). One transaction in flight. Per-port ready pulses let the pipeline stall while
//  waiting. D wins by default; a streak limit prevents I starvation. A timeout recovers from a backing memory
//  that never acknowledges.
// PARAMETERS
//  ADDR_W        32   address width, all ports
//  DATA_W        32   data width, all ports
//  MAX_D_STREAK  4    consecutive D grants allowed while I waits, then I is forced (1..15)
//  TIMEOUT       64   cycles in BUSY without mem_ack before abort; 0 disables the timeout
// PORTS
//  clock       in   1       single clock, rising edge
//  reset       in   1       asynchronous, active-high
//  if_req      in   1       fetch request; level, held with if_addr until if_ready
//  if_addr     in   ADDR_W  fetch word address
//  if_ready    out  1       one-cycle pulse: fetch done, if_rdata valid
//  if_rdata    out  DATA_W  fetched word; held until next I completion
//  d_req       in   1       data request; level, held with d_we/d_byte/d_addr/d_wdata until d_ready
//  d_we        in   1       1 = store, 0 = load
//  d_byte      in   1       byte access (lbu/sb)
//  d_addr      in   ADDR_W  data address
//  d_wdata     in   DATA_W  store data
//  d_ready     out  1       one-cycle pulse: data access done
//  d_rdata     out  DATA_W  load data; updated only on D reads, held otherwise
//  mem_req     out  1       backing request; high for the whole transaction
//  mem_we      out  1       write enable; mem_byte, mem_addr, mem_wdata stable while mem_req=1
//  mem_byte    out  1       byte access
//  mem_addr    out  ADDR_W  address
//  mem_wdata   out  DATA_W  write data
//  mem_ack     in   1       completion; valid only while mem_req=1; mem_rdata valid in the same cycle
//  mem_rdata   in   DATA_W  read data
//  bus_err     out  1       sticky; set on timeout, cleared only by reset
// BEHAVIOUR
//  - Reset (async): state IDLE; every output is 0, including the rdata registers, streak and timer.
//      A transaction in flight is abandoned; the backing memory is on the same reset.
//  - FSM: IDLE, I_BUSY, D_BUSY. All outputs are registered.
//  - IDLE, sampled at edge k:
//      - d_req only: go to D_BUSY.
//      - if_req only: go to I_BUSY.
//      - both: go to I_BUSY if streak == MAX_D_STREAK, else D_BUSY.
//      - Whichever is granted: mem_req=1 and the mem_* fields load from the granted port after edge k.
//  - BUSY with mem_ack=1 at edge n:
//      - mem_req falls to 0 and state returns to IDLE.
//      - The granted port's ready=1 for the cycle after n.
//      - I: if_rdata <= mem_rdata. D read: d_rdata <= mem_rdata. D write: d_rdata unchanged.
//  - Minimum latency: request seen at edge k, mem_ack in the first BUSY cycle -> ready high after edge k+1.
//  - Ready cycle: state is IDLE. A req still high in that cycle is a new request (back-to-back streaming).
//      The requester must present its next address/fields or drop req combinationally on ready.
//  - Streak: +1 on each D grant while if_req=1 (saturates at MAX_D_STREAK).
//      Cleared on any I grant, and on a D grant made while if_req=0.
//  - Timer: cleared on entry to BUSY, +1 per BUSY cycle without mem_ack.
//  - Timeout: TIMEOUT!=0 and timer == TIMEOUT-1 with no mem_ack ->
//      - mem_req dropped, state returns to IDLE, bus_err set.
//      - The granted port gets its ready pulse with rdata = 32'hDEAD_BEEF; a D write leaves d_rdata unchanged.
//      - Dropping mem_req cancels the transaction; mem_ack at that same edge still completes normally.
//  - mem_ack while IDLE is ignored.
//  - Port inputs changing while that port is granted are not observed; mem_* hold the values latched at grant.
// STRUCTURE
//  - Shared constants header mem_arb_defs.vh (include-guarded), which holds:
//      - state encodings ARB_IDLE/ARB_I_BUSY/ARB_D_BUSY
//      - ARB_ERR_DATA = 32'hDEAD_BEEF
//  - One natural sub-module, mem_arb_timer: the timeout counter with clear/enable inputs and an expired output.
//  - Grant selection stays inline in the FSM.
// TESTING
//  1 I only: if_req=1, addr 0x3000; mem_ack in the 2nd BUSY cycle, rdata 0x2008_0005
//      -> if_ready pulses once, if_rdata=0x2008_0005, d_ready stays 0.
//  2 Simultaneous: if_req and d_req (load 0x1000) rise together
//      -> D granted first (mem_addr=0x1000, mem_we=0), then I granted back-to-back after d_ready.
//  3 Starvation: d_req held continuously with if_req=1, MAX_D_STREAK=4
//      -> grants D,D,D,D,I,D...; exactly 4 D grants precede the I grant.
//  4 Store byte: d_we=1, d_byte=1, d_addr=0x1003, d_wdata=0xAB
//      -> mem_we=1, mem_byte=1, fields stable until mem_ack; d_rdata unchanged after d_ready.
//  5 Timeout (TIMEOUT=8): mem_ack never asserted on an I fetch
//      -> mem_req drops after 8 BUSY cycles; if_ready pulses with 0xDEAD_BEEF; bus_err=1 until reset.
//  6 Reset mid-transaction: assert reset during D_BUSY, off-edge
//      -> mem_req, ready pulses, rdata, bus_err all 0 immediately; first grant after release is fresh.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Types and helpers shared by the memory port arbiter and its timeout counter.
`include "mem_arb_defs.vh"

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = `ARB_IDLE,
    ST_I_BUSY = `ARB_I_BUSY,
    ST_D_BUSY = `ARB_D_BUSY
  } arbState_t;

  localparam logic [31:0] ERR_DATA = `ARB_ERR_DATA;

  function automatic logic [3:0] satInc(input logic [3:0] val, input logic [3:0] lim);
    return (val >= lim) ? lim : val + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arb_defs.vh
// Shared encodings and constants for the memory port arbiter.
`ifndef MEM_ARB_DEFS_VH
`define MEM_ARB_DEFS_VH

`define ARB_IDLE     2'd0
`define ARB_I_BUSY   2'd1
`define ARB_D_BUSY   2'd2
`define ARB_ERR_DATA 32'hDEAD_BEEF

`endif

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter; o_expired flags the last allowed cycle before abort.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIMIT_V = LIMIT[CW-1:0];

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)       r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + CW'(1);
  end

  // A zero TIMEOUT disables expiry entirely; the counter then just wraps.
  assign o_expired = (TIMEOUT != 0) && (r_count == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported backing memory between instruction-fetch and data ports.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ready,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic              i_d_byte,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ready,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic              o_mem_byte,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_bus_err
);

  localparam logic [3:0]        STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [DATA_W-1:0] ERR_WORD   = DATA_W'(ERR_DATA);

  arbState_t  r_state, w_nextState;
  logic       w_grantI, w_grantD, w_ack, w_timeout, w_done, w_expired;
  logic [3:0] r_dStreak;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (r_state == ST_IDLE),
    .i_enable ((r_state != ST_IDLE) && !i_mem_ack),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_grantI    = 1'b0;
    w_grantD    = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // D wins unless I has waited through a full streak of D grants.
        if (i_d_req && !(i_if_req && (r_dStreak == STREAK_MAX))) w_grantD = 1'b1;
        else if (i_if_req)                                       w_grantI = 1'b1;
        if (w_grantD)      w_nextState = ST_D_BUSY;
        else if (w_grantI) w_nextState = ST_I_BUSY;
      end
      ST_I_BUSY, ST_D_BUSY: begin
        w_ack     = i_mem_ack;
        w_timeout = !i_mem_ack && w_expired;
        w_done    = w_ack || w_timeout;
        if (w_done) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_if_ready  <= 1'b0;
      o_if_rdata  <= '0;
      o_d_ready   <= 1'b0;
      o_d_rdata   <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_byte  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_bus_err   <= 1'b0;
      r_dStreak   <= '0;
    end else begin
      o_if_ready <= w_done && (r_state == ST_I_BUSY);
      o_d_ready  <= w_done && (r_state == ST_D_BUSY);
      o_mem_req  <= (w_nextState != ST_IDLE);
      if (w_grantD) begin
        o_mem_we    <= i_d_we;
        o_mem_byte  <= i_d_byte;
        o_mem_addr  <= i_d_addr;
        o_mem_wdata <= i_d_wdata;
        r_dStreak   <= i_if_req ? satInc(r_dStreak, STREAK_MAX) : 4'd0;
      end else if (w_grantI) begin
        o_mem_we    <= 1'b0;
        o_mem_byte  <= 1'b0;
        o_mem_addr  <= i_if_addr;
        o_mem_wdata <= '0;
        r_dStreak   <= 4'd0;
      end
      // An aborted read returns the error marker instead of stale data.
      if (w_done && (r_state == ST_I_BUSY))
        o_if_rdata <= w_ack ? i_mem_rdata : ERR_WORD;
      if (w_done && (r_state == ST_D_BUSY) && !o_mem_we)
        o_d_rdata <= w_ack ? i_mem_rdata : ERR_WORD;
      if (w_timeout) o_bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_D_STREAK=4, TIMEOUT=8).
module tb_mem_port_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        o_if_ready;
  logic [31:0] o_if_rdata;
  logic        i_d_req = 1'b0;
  logic        i_d_we = 1'b0;
  logic        i_d_byte = 1'b0;
  logic [31:0] i_d_addr = '0;
  logic [31:0] i_d_wdata = '0;
  logic        o_d_ready;
  logic [31:0] o_d_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic        o_mem_byte;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_bus_err;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 i_clock = ~i_clock;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(8)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_ready(o_if_ready), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_byte(i_d_byte),
    .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_ready(o_d_ready), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_byte(o_mem_byte),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_bus_err(o_bus_err)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic dReq, input logic dWe, input logic dByte,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    i_if_req  = ifReq;
    i_if_addr = ifAddr;
    i_d_req   = dReq;
    i_d_we    = dWe;
    i_d_byte  = dByte;
    i_d_addr  = dAddr;
    i_d_wdata = dWdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] expAddr [6];
    expAddr = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h3008, 32'h2000};

    // Reset state
    tick();
    tick();
    i_reset = 1'b0;
    tick();
    checkOutput("rst_mem_req", 32'(o_mem_req), 32'd0);
    checkOutput("rst_if_ready", 32'(o_if_ready), 32'd0);
    checkOutput("rst_d_ready", 32'(o_d_ready), 32'd0);
    checkOutput("rst_if_rdata", o_if_rdata, 32'd0);
    checkOutput("rst_d_rdata", o_d_rdata, 32'd0);
    checkOutput("rst_bus_err", 32'(o_bus_err), 32'd0);

    // I only, ack in second busy cycle
    applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("t1_mem_req", 32'(o_mem_req), 32'd1);
    checkOutput("t1_mem_addr", o_mem_addr, 32'h3000);
    checkOutput("t1_mem_we", 32'(o_mem_we), 32'd0);
    tick();
    checkOutput("t1_no_ready_yet", 32'(o_if_ready), 32'd0);
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h2008_0005;
    tick();
    checkOutput("t1_if_ready", 32'(o_if_ready), 32'd1);
    checkOutput("t1_if_rdata", o_if_rdata, 32'h2008_0005);
    checkOutput("t1_d_ready", 32'(o_d_ready), 32'd0);
    checkOutput("t1_mem_req_low", 32'(o_mem_req), 32'd0);
    i_if_req = 1'b0;
    i_mem_ack = 1'b0;
    tick();
    checkOutput("t1_ready_pulse", 32'(o_if_ready), 32'd0);

    // Simultaneous: D first, then I back-to-back
    applyStimulus(1'b1, 32'h3004, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h0);
    tick();
    checkOutput("t2_d_addr", o_mem_addr, 32'h1000);
    checkOutput("t2_d_we", 32'(o_mem_we), 32'd0);
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h1111_2222;
    tick();
    checkOutput("t2_d_ready", 32'(o_d_ready), 32'd1);
    checkOutput("t2_d_rdata", o_d_rdata, 32'h1111_2222);
    checkOutput("t2_if_ready_low", 32'(o_if_ready), 32'd0);
    i_d_req = 1'b0;
    i_mem_ack = 1'b0;
    tick();
    checkOutput("t2_i_addr", o_mem_addr, 32'h3004);
    checkOutput("t2_i_mem_req", 32'(o_mem_req), 32'd1);
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h3333_4444;
    tick();
    checkOutput("t2_if_ready", 32'(o_if_ready), 32'd1);
    checkOutput("t2_if_rdata", o_if_rdata, 32'h3333_4444);
    checkOutput("t2_d_rdata_held", o_d_rdata, 32'h1111_2222);
    i_if_req = 1'b0;
    i_mem_ack = 1'b0;
    tick();

    // Starvation: D,D,D,D,I,D with both requests held
    applyStimulus(1'b1, 32'h3008, 1'b1, 1'b0, 1'b0, 32'h2000, 32'h0);
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h5555_6666;
    for (int g = 0; g < 6; g++) begin
      tick();
      checkOutput($sformatf("t3_grant%0d_addr", g), o_mem_addr, expAddr[g]);
      tick();
      checkOutput($sformatf("t3_grant%0d_if_ready", g), 32'(o_if_ready), (g == 4) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    i_mem_ack = 1'b0;
    tick();

    // Store byte; fields stay latched while port inputs change
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h1003, 32'h0000_00AB);
    tick();
    checkOutput("t4_mem_we", 32'(o_mem_we), 32'd1);
    checkOutput("t4_mem_byte", 32'(o_mem_byte), 32'd1);
    checkOutput("t4_mem_addr", o_mem_addr, 32'h1003);
    checkOutput("t4_mem_wdata", o_mem_wdata, 32'h0000_00AB);
    i_d_addr = 32'h9999;
    i_d_wdata = 32'hFF;
    tick();
    checkOutput("t4_addr_stable", o_mem_addr, 32'h1003);
    checkOutput("t4_wdata_stable", o_mem_wdata, 32'h0000_00AB);
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hCAFE_F00D;
    tick();
    checkOutput("t4_d_ready", 32'(o_d_ready), 32'd1);
    checkOutput("t4_d_rdata_kept", o_d_rdata, 32'h5555_6666);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    i_mem_ack = 1'b0;
    tick();

    // Timeout on an I fetch after 8 busy cycles
    applyStimulus(1'b1, 32'h300C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("t5_busy1_req", 32'(o_mem_req), 32'd1);
    for (int c = 2; c <= 8; c++) begin
      tick();
      checkOutput($sformatf("t5_busy%0d_req", c), 32'(o_mem_req), 32'd1);
    end
    checkOutput("t5_err_before", 32'(o_bus_err), 32'd0);
    tick();
    checkOutput("t5_mem_req_drop", 32'(o_mem_req), 32'd0);
    checkOutput("t5_if_ready", 32'(o_if_ready), 32'd1);
    checkOutput("t5_if_rdata", o_if_rdata, 32'hDEAD_BEEF);
    checkOutput("t5_bus_err", 32'(o_bus_err), 32'd1);
    i_if_req = 1'b0;
    tick();
    checkOutput("t5_bus_err_sticky", 32'(o_bus_err), 32'd1);
    checkOutput("t5_ready_pulse", 32'(o_if_ready), 32'd0);

    // Reset mid-transaction, asserted away from the clock edge
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1004, 32'h0);
    tick();
    checkOutput("t6_busy_req", 32'(o_mem_req), 32'd1);
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("t6_rst_mem_req", 32'(o_mem_req), 32'd0);
    checkOutput("t6_rst_bus_err", 32'(o_bus_err), 32'd0);
    checkOutput("t6_rst_if_rdata", o_if_rdata, 32'd0);
    checkOutput("t6_rst_d_rdata", o_d_rdata, 32'd0);
    checkOutput("t6_rst_d_ready", 32'(o_d_ready), 32'd0);
    #2;
    i_reset = 1'b0;
    tick();
    checkOutput("t6_fresh_req", 32'(o_mem_req), 32'd1);
    checkOutput("t6_fresh_addr", o_mem_addr, 32'h1004);
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h7777_8888;
    tick();
    checkOutput("t6_d_ready", 32'(o_d_ready), 32'd1);
    checkOutput("t6_d_rdata", o_d_rdata, 32'h7777_8888);
    i_d_req = 1'b0;
    i_mem_ack = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
